// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative
// RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int LEN = 32
);
    logic           start;
    logic [2:0]     funct3;
    logic [LEN-1:0] aluop1;
    logic [LEN-1:0] aluop2;
    logic           flush;
    logic           ready;
    logic           busy;
    logic           valid_out;
    logic [LEN-1:0] aluout;

    modport master (
        output start, funct3, aluop1, aluop2, flush,
        input  ready, busy, valid_out, aluout
    );

    modport slave (
        input  start, funct3, aluop1, aluop2, flush,
        output ready, busy, valid_out, aluout
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide, one step per cycle, with start/busy/valid handshake and flush.
module muldiv_unit #(
    parameter int LEN   = 32,
    parameter int CNT_W = $clog2(LEN) + 1
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       op, op_n;
    logic             neg_res, neg_res_n;
    logic             neg_rem, neg_rem_n;
    logic [LEN:0]     hi, hi_n;
    logic [LEN-1:0]   lo, lo_n;
    logic [LEN-1:0]   opb, opb_n;
    logic [LEN-1:0]   res, res_n;

    logic             a_sgn, b_sgn, sgn_ops, accept;
    logic [LEN-1:0]   a_mag, b_mag;
    logic [LEN:0]     mul_sum, shifted, diff;
    logic [LEN:0]     step_hi;
    logic [LEN-1:0]   step_lo;
    logic [2*LEN-1:0] prod, prod_s;
    logic [LEN-1:0]   quo_s, rem_s, fin;

    assign bus.ready     = (state != RUN);
    assign bus.busy      = (state == RUN);
    assign bus.valid_out = (state == DONE);
    assign bus.aluout    = res;

    // Operand sign handling at accept time
    always_comb begin
        sgn_ops = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        a_sgn   = (sgn_ops || (bus.funct3 == 3'b010)) && bus.aluop1[LEN-1];
        b_sgn   = sgn_ops && bus.aluop2[LEN-1];
        a_mag   = a_sgn ? (~bus.aluop1 + 1'b1) : bus.aluop1;
        b_mag   = b_sgn ? (~bus.aluop2 + 1'b1) : bus.aluop2;
        accept  = bus.start && !bus.flush && (state != RUN);
    end

    // One iteration of multiply (hi:lo shift right) or divide (hi:lo shift left)
    always_comb begin
        mul_sum = hi + (lo[0] ? {1'b0, opb} : '0);
        shifted = {hi[LEN-1:0], lo[LEN-1]};
        diff    = shifted - {1'b0, opb};
        if (op[2]) begin
            if (!diff[LEN]) begin
                step_hi = diff;
                step_lo = {lo[LEN-2:0], 1'b1};
            end else begin
                step_hi = shifted;
                step_lo = {lo[LEN-2:0], 1'b0};
            end
        end else begin
            step_hi = {1'b0, mul_sum[LEN:1]};
            step_lo = {mul_sum[0], lo[LEN-1:1]};
        end
        prod   = {step_hi[LEN-1:0], step_lo};
        prod_s = neg_res ? (~prod + 1'b1) : prod;
        quo_s  = neg_res ? (~step_lo + 1'b1) : step_lo;
        rem_s  = neg_rem ? (~step_hi[LEN-1:0] + 1'b1) : step_hi[LEN-1:0];
        case (op)
            3'b000:                 fin = prod_s[LEN-1:0];
            3'b001, 3'b010, 3'b011: fin = prod_s[2*LEN-1:LEN];
            3'b100, 3'b101:         fin = quo_s;
            default:                fin = rem_s;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        op_n      = op;
        neg_res_n = neg_res;
        neg_rem_n = neg_rem;
        hi_n      = hi;
        lo_n      = lo;
        opb_n     = opb;
        res_n     = res;

        if (bus.flush) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            if (state == RUN) begin
                hi_n  = step_hi;
                lo_n  = step_lo;
                cnt_n = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_n = DONE;
                    res_n   = fin;
                end
            end else if (state == DONE) begin
                state_n = IDLE;
            end

            if (accept) begin
                op_n      = bus.funct3;
                neg_res_n = a_sgn ^ b_sgn;
                neg_rem_n = a_sgn;
                hi_n      = '0;
                cnt_n     = CNT_W'(LEN);
                state_n   = RUN;
                if (bus.funct3[2]) begin
                    lo_n  = a_mag;
                    opb_n = b_mag;
                end else begin
                    lo_n  = b_mag;
                    opb_n = a_mag;
                end
                // Divide corner cases resolve immediately without iterating
                if (bus.funct3[2] && (bus.aluop2 == '0)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                    res_n   = bus.funct3[1] ? bus.aluop1 : '1;
                end else if (bus.funct3[2] && !bus.funct3[0] &&
                             (bus.aluop1 == {1'b1, {(LEN-1){1'b0}}}) &&
                             (bus.aluop2 == '1)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                    res_n   = bus.funct3[1] ? '0 : bus.aluop1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            opb     <= '0;
            res     <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            op      <= op_n;
            neg_res <= neg_res_n;
            neg_rem <= neg_rem_n;
            hi      <= hi_n;
            lo      <= lo_n;
            opb     <= opb_n;
            res     <= res_n;
        end
    end
endmodule
